// File: rtl/cmp_arbiter.sv
// Two-port arbitrated signed 32-bit comparator (LT/NE/EQ/GE) with captured operands.
// Latency: accept edge -> resp_valid after 2 edges; one request in flight, issue interval 3 cycles.
// Backpressure: req_ready only in IDLE for the granted port; DONE holds until the owner's resp_ready.
module cmp_arbiter #(
   parameter bit RR_EN = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid0,
   input  logic        req_valid1,
   output logic        req_ready0,
   output logic        req_ready1,
   input  logic [31:0] req_a0,
   input  logic [31:0] req_b0,
   input  logic [31:0] req_a1,
   input  logic [31:0] req_b1,
   input  logic [1:0]  req_op0,
   input  logic [1:0]  req_op1,
   output logic        resp_valid0,
   output logic        resp_valid1,
   input  logic        resp_ready0,
   input  logic        resp_ready1,
   output logic        resp_result,
   output logic        resp_lt,
   output logic        resp_ne,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] OP_LT = 2'b00;
   localparam logic [1:0] OP_NE = 2'b01;
   localparam logic [1:0] OP_EQ = 2'b10;

   state_t      state_q;
   state_t      state_d;
   logic        last_served;
   logic        grant;
   logic        accept;
   logic [31:0] cap_a;
   logic [31:0] cap_b;
   logic [1:0]  cap_op;
   logic        cap_id;
   logic [31:0] diff;
   logic        lt_c;
   logic        ne_c;
   logic        result_c;
   logic        result_q;
   logic        lt_q;
   logic        ne_q;

   assign busy        = (state_q != IDLE);
   assign resp_result = result_q;
   assign resp_lt     = lt_q;
   assign resp_ne     = ne_q;

   // Grant selection: a lone requester wins; a tie goes to the port not served last (or port 0 when fixed).
   always_comb begin
      grant = 1'b0;
      if (req_valid0 && req_valid1) begin
         grant = RR_EN ? ~last_served : 1'b0;
      end else if (req_valid1) begin
         grant = 1'b1;
      end
   end

   // Subtract-based signed compare; when signs differ the subtraction may overflow, so a's sign decides.
   always_comb begin
      diff     = cap_a - cap_b;
      lt_c     = (cap_a[31] ^ cap_b[31]) ? cap_a[31] : diff[31];
      ne_c     = |diff;
      result_c = ~lt_c;
      case (cap_op)
         OP_LT:   result_c = lt_c;
         OP_NE:   result_c = ne_c;
         OP_EQ:   result_c = ~ne_c;
         default: result_c = ~lt_c;
      endcase
   end

   // State register; reset drops any in-flight request without a response.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and handshake outputs; ready is gated by reset so it drops immediately.
   always_comb begin
      state_d     = state_q;
      req_ready0  = 1'b0;
      req_ready1  = 1'b0;
      resp_valid0 = 1'b0;
      resp_valid1 = 1'b0;
      accept      = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready0 = ~reset & req_valid0 & ~grant;
            req_ready1 = ~reset & req_valid1 & grant;
            if (req_ready0 || req_ready1) begin
               accept  = 1'b1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            state_d = DONE;
         end
         DONE: begin
            resp_valid0 = ~cap_id;
            resp_valid1 = cap_id;
            // Only the owning port's resp_ready retires the response.
            if (cap_id ? resp_ready1 : resp_ready0) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Operand capture on accept, arbitration history, and result registration in BUSY.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cap_a       <= '0;
         cap_b       <= '0;
         cap_op      <= '0;
         cap_id      <= 1'b0;
         last_served <= 1'b1;
         result_q    <= 1'b0;
         lt_q        <= 1'b0;
         ne_q        <= 1'b0;
      end else begin
         if (accept) begin
            cap_a       <= grant ? req_a1 : req_a0;
            cap_b       <= grant ? req_b1 : req_b0;
            cap_op      <= grant ? req_op1 : req_op0;
            cap_id      <= grant;
            last_served <= grant;
         end
         if (state_q == BUSY) begin
            result_q <= result_c;
            lt_q     <= lt_c;
            ne_q     <= ne_c;
         end
      end
   end

endmodule

// File: tb/tb_cmp_arbiter.sv
// Scoreboard bench for cmp_arbiter: round-robin instance plus a fixed-priority instance.
// Stimulus pushes expected responses; negedge monitors pop and compare on each response handshake.
// Directed vectors cover latency, overflow, ties, fixed priority, backpressure and mid-flight reset.
module tb_cmp_arbiter;

   typedef struct packed {
      logic port;
      logic result;
      logic lt;
      logic ne;
   } exp_t;

   logic        clock;
   logic        reset;
   logic        req_valid0, req_valid1, req_ready0, req_ready1;
   logic [31:0] req_a0, req_b0, req_a1, req_b1;
   logic [1:0]  req_op0, req_op1;
   logic        resp_valid0, resp_valid1, resp_ready0, resp_ready1;
   logic        resp_result, resp_lt, resp_ne, busy;

   logic        fp_req_valid0, fp_req_valid1, fp_req_ready0, fp_req_ready1;
   logic [31:0] fp_a0, fp_b0, fp_a1, fp_b1;
   logic [1:0]  fp_op0, fp_op1;
   logic        fp_resp_valid0, fp_resp_valid1, fp_resp_ready0, fp_resp_ready1;
   logic        fp_result, fp_lt, fp_ne, fp_busy;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t q_rr[$];
   exp_t q_fp[$];

   cmp_arbiter #(.RR_EN(1'b1)) u_rr (
      .clock(clock), .reset(reset),
      .req_valid0(req_valid0), .req_valid1(req_valid1),
      .req_ready0(req_ready0), .req_ready1(req_ready1),
      .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
      .req_op0(req_op0), .req_op1(req_op1),
      .resp_valid0(resp_valid0), .resp_valid1(resp_valid1),
      .resp_ready0(resp_ready0), .resp_ready1(resp_ready1),
      .resp_result(resp_result), .resp_lt(resp_lt), .resp_ne(resp_ne),
      .busy(busy)
   );

   cmp_arbiter #(.RR_EN(1'b0)) u_fp (
      .clock(clock), .reset(reset),
      .req_valid0(fp_req_valid0), .req_valid1(fp_req_valid1),
      .req_ready0(fp_req_ready0), .req_ready1(fp_req_ready1),
      .req_a0(fp_a0), .req_b0(fp_b0), .req_a1(fp_a1), .req_b1(fp_b1),
      .req_op0(fp_op0), .req_op1(fp_op1),
      .resp_valid0(fp_resp_valid0), .resp_valid1(fp_resp_valid1),
      .resp_ready0(fp_resp_ready0), .resp_ready1(fp_resp_ready1),
      .resp_result(fp_result), .resp_lt(fp_lt), .resp_ne(fp_ne),
      .busy(fp_busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check1(input string name, input logic act, input logic exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0b, expected %0b", name, act, exp_v);
      end
   endtask

   task automatic check32(input string name, input int act, input int exp_v);
      n_cmp++;
      if (act != exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
      end
   endtask

   function automatic exp_t mk(input logic p, input logic r, input logic l, input logic n);
      return {p, r, l, n};
   endfunction

   task automatic cmp_resp(input string tag, input exp_t e, input logic p, input logic r,
                           input logic l, input logic n);
      check1({tag, "_port"}, p, e.port);
      check1({tag, "_result"}, r, e.result);
      check1({tag, "_lt"}, l, e.lt);
      check1({tag, "_ne"}, n, e.ne);
   endtask

   // Round-robin instance monitor
   always @(negedge clock) begin
      if (resp_valid0 && resp_valid1) check1("rr_one_hot_valid", resp_valid0 & resp_valid1, 1'b0);
      if ((resp_valid0 && resp_ready0) || (resp_valid1 && resp_ready1)) begin
         check1("rr_resp_expected", q_rr.size() != 0, 1'b1);
         if (q_rr.size() != 0) cmp_resp("rr", q_rr.pop_front(), resp_valid1, resp_result, resp_lt, resp_ne);
      end
   end

   // Fixed-priority instance monitor
   always @(negedge clock) begin
      if ((fp_resp_valid0 && fp_resp_ready0) || (fp_resp_valid1 && fp_resp_ready1)) begin
         check1("fp_resp_expected", q_fp.size() != 0, 1'b1);
         if (q_fp.size() != 0) cmp_resp("fp", q_fp.pop_front(), fp_resp_valid1, fp_result, fp_lt, fp_ne);
      end
   end

   task automatic send(input logic p, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] op, output int w);
      bit hit;
      hit = 1'b0;
      w   = 0;
      if (!p) begin req_valid0 = 1'b1; req_a0 = a; req_b0 = b; req_op0 = op; end
      else    begin req_valid1 = 1'b1; req_a1 = a; req_b1 = b; req_op1 = op; end
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         w++;
         if ((!p && req_ready0) || (p && req_ready1)) begin
            hit = 1'b1;
            break;
         end
      end
      check1("send_accepted", hit, 1'b1);
      @(posedge clock); #1;
      // Scramble operands after acceptance; the captured copy must be used.
      if (!p) begin req_valid0 = 1'b0; req_a0 = ~a; req_b0 = ~b; req_op0 = ~op; end
      else    begin req_valid1 = 1'b0; req_a1 = ~a; req_b1 = ~b; req_op1 = ~op; end
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 40; i++) begin
         if (q_rr.size() == 0 && q_fp.size() == 0) break;
         @(negedge clock);
      end
      check32({tag, "_drain_rr"}, q_rr.size(), 0);
      check32({tag, "_drain_fp"}, q_fp.size(), 0);
      @(posedge clock); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, n, cyc, last_cyc;
      bit seen1;
      reset = 1'b1;
      req_valid0 = 1'b1; req_valid1 = 1'b0;
      req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0; req_op0 = '0; req_op1 = '0;
      resp_ready0 = 1'b1; resp_ready1 = 1'b1;
      fp_req_valid0 = 1'b0; fp_req_valid1 = 1'b0;
      fp_a0 = '0; fp_b0 = '0; fp_a1 = '0; fp_b1 = '0; fp_op0 = '0; fp_op1 = '0;
      fp_resp_ready0 = 1'b1; fp_resp_ready1 = 1'b1;

      // Reset state, with a requester valid to show ready stays low
      repeat (2) @(negedge clock);
      check1("rst_busy", busy, 1'b0);
      check1("rst_ready0", req_ready0, 1'b0);
      check1("rst_ready1", req_ready1, 1'b0);
      check1("rst_resp_valid0", resp_valid0, 1'b0);
      check1("rst_resp_valid1", resp_valid1, 1'b0);
      check1("rst_result", resp_result, 1'b0);
      check1("rst_lt", resp_lt, 1'b0);
      check1("rst_ne", resp_ne, 1'b0);
      @(posedge clock); #1;
      reset = 1'b0;
      req_valid0 = 1'b0;

      // Single request: 5 < 7
      q_rr.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1));
      send(1'b0, 32'd5, 32'd7, 2'b00, w);
      check32("t1_accept_cycle", w, 1);
      @(negedge clock);
      check1("t1_busy", busy, 1'b1);
      check1("t1_resp_valid_early", resp_valid0, 1'b0);
      @(negedge clock);
      check1("t1_resp_valid_2edges", resp_valid0, 1'b1);
      drain("t1");

      // Overflow corner: 0x80000000 GE 0x7FFFFFFF is false
      q_rr.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1));
      send(1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 2'b11, w);
      drain("t2");

      // Round-robin tie: EQ on 3,3 from both ports; last served was port 1
      for (int k = 0; k < 4; k++) q_rr.push_back(mk(k[0], 1'b1, 1'b0, 1'b0));
      req_valid0 = 1'b1; req_a0 = 32'd3; req_b0 = 32'd3; req_op0 = 2'b10;
      req_valid1 = 1'b1; req_a1 = 32'd3; req_b1 = 32'd3; req_op1 = 2'b10;
      n = 0; last_cyc = 0;
      for (cyc = 0; cyc < 40; cyc++) begin
         @(negedge clock);
         if (req_ready0 || req_ready1) begin
            check1("tie_grant_port", req_ready1, n[0]);
            if (n > 0) check32("tie_interval", cyc - last_cyc, 3);
            last_cyc = cyc;
            n++;
            if (n == 4) break;
         end
      end
      check32("tie_grants", n, 4);
      @(posedge clock); #1;
      req_valid0 = 1'b0; req_valid1 = 1'b0;
      drain("t3");

      // Backpressure: port0 result held while port1 waits
      resp_ready0 = 1'b0;
      q_rr.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1));
      q_rr.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1));
      send(1'b0, 32'hFFFF_FFFF, 32'd1, 2'b11, w);
      req_valid1 = 1'b1; req_a1 = 32'd10; req_b1 = 32'hFFFF_FFFC; req_op1 = 2'b11;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (resp_valid0) break;
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check1("bp_resp_valid0", resp_valid0, 1'b1);
         check1("bp_result", resp_result, 1'b0);
         check1("bp_lt", resp_lt, 1'b1);
         check1("bp_ne", resp_ne, 1'b1);
         check1("bp_busy", busy, 1'b1);
         check1("bp_ready1", req_ready1, 1'b0);
      end
      @(posedge clock); #1;
      resp_ready0 = 1'b1;
      @(negedge clock);
      check1("bp_ready1_consume_cycle", req_ready1, 1'b0);
      @(negedge clock);
      check1("bp_ready1_after", req_ready1, 1'b1);
      @(posedge clock); #1;
      req_valid1 = 1'b0;
      drain("t4");

      // Reset while BUSY: request dropped, next tie to port 0
      send(1'b0, 32'd1, 32'd2, 2'b00, w);
      #3 reset = 1'b1;
      #1;
      check1("rstb_busy", busy, 1'b0);
      check1("rstb_resp_valid0", resp_valid0, 1'b0);
      @(posedge clock); #1;
      check1("rstb_resp_valid0_edge", resp_valid0, 1'b0);
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check1("rstb_no_resp", resp_valid0 | resp_valid1, 1'b0);
      end
      @(posedge clock); #1;
      q_rr.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1));
      req_valid0 = 1'b1; req_a0 = 32'd1; req_b0 = 32'd2; req_op0 = 2'b00;
      req_valid1 = 1'b1; req_a1 = 32'd1; req_b1 = 32'd2; req_op1 = 2'b00;
      @(negedge clock);
      check1("rstb_tie_ready0", req_ready0, 1'b1);
      check1("rstb_tie_ready1", req_ready1, 1'b0);
      @(posedge clock); #1;
      req_valid0 = 1'b0; req_valid1 = 1'b0;
      drain("t5");

      // Fixed priority: port 0 takes every tie
      for (int k = 0; k < 3; k++) q_fp.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0));
      fp_req_valid0 = 1'b1; fp_a0 = 32'd3; fp_b0 = 32'd3; fp_op0 = 2'b10;
      fp_req_valid1 = 1'b1; fp_a1 = 32'd3; fp_b1 = 32'd3; fp_op1 = 2'b10;
      n = 0; seen1 = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (fp_req_ready1) seen1 = 1'b1;
         if (fp_req_ready0) begin
            n++;
            if (n == 3) break;
         end
      end
      @(posedge clock); #1;
      fp_req_valid0 = 1'b0; fp_req_valid1 = 1'b0;
      check32("fp_port0_grants", n, 3);
      check1("fp_ready1_never", seen1, 1'b0);
      drain("t6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cmp_arbiter.md
CMP_ARBITER -- requirements
Module: cmp_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1: 1 = round-robin arbitration; 0 = fixed priority, port 0 always wins.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have ports req_valid0 and req_valid1, input, 1 bit each: requester k presents a compare.
REQ-005 SHALL have ports req_ready0 and req_ready1, output, 1 bit each: the request on port k is accepted this cycle.
REQ-006 SHALL have ports req_a0, req_b0, req_a1 and req_b1, input, 32 bits each: signed two's-complement operands.
REQ-007 SHALL have ports req_op0 and req_op1, input, 2 bits each: 00 LT, 01 NE, 10 EQ, 11 GE.
REQ-008 SHALL have ports resp_valid0 and resp_valid1, output, 1 bit each: a result is available for port k.
REQ-009 SHALL have ports resp_ready0 and resp_ready1, input, 1 bit each: requester k consumes the response.
REQ-010 SHALL have port resp_result, output, 1 bit: the op-selected compare outcome.
REQ-011 SHALL have ports resp_lt and resp_ne, output, 1 bit each: the raw signed-less-than and not-equal flags.
REQ-012 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-013 SHALL implement an FSM with states IDLE, BUSY and DONE; the reset state is IDLE.
REQ-014 SHALL, in IDLE, assert req_ready_k combinationally only for the granted port k, and only when req_valid_k is high; ready is never high in BUSY or DONE.
REQ-015 SHALL grant as follows: one valid port wins alone; with both valid and RR_EN=1, the port not served last wins; with both valid and RR_EN=0, port 0 wins.
REQ-016 SHALL hold the last-served pointer at 1 out of reset, so port 0 wins the first tie.
REQ-017 SHALL, on a handshake (valid and ready high at an edge), capture a, b, op and the port id into internal registers, update last-served and move to BUSY.
REQ-018 SHALL, in BUSY, compute a signed 32-bit compare on the captured operands using subtract-based logic, register lt, ne and the op-selected result, and move to DONE.
REQ-019 SHALL compute lt correctly across overflow: when the operand signs differ, lt = a[31]; otherwise lt = the sign of a-b.
REQ-020 SHALL compute ne = (a != b), EQ = !ne and GE = !lt.
REQ-021 SHALL, in DONE, drive resp_valid_k high only for the captured port id, and hold resp_result, resp_lt and resp_ne stable until the response is consumed.
REQ-022 SHALL move DONE to IDLE on an edge where resp_valid_k and resp_ready_k are both high; resp_ready of the non-owning port is ignored.
REQ-023 SHALL give latency from accept edge to resp_valid of 2 edges, and a minimum issue interval of 3 cycles; no request is accepted in the cycle the response is consumed.
REQ-024 SHALL hold resp_result, resp_lt and resp_ne at their last registered values outside DONE; they are meaningful only while resp_valid is high.
REQ-025 SHALL ignore operand or op changes on a requester after acceptance; the captured copy is used.
REQ-026 SHALL leave a requester not granted in a tie with ready low; it is served next under RR_EN=1, with no starvation.

Reset
REQ-027 SHALL, with reset high, immediately force state IDLE, all req_ready and resp_valid low, busy 0, result/lt/ne 0 and last-served 1, regardless of clock.
REQ-028 SHALL, on reset asserted mid-operation (BUSY or DONE), discard the in-flight request with no response ever issued; after release, the first tie goes to port 0.

Verification
REQ-029 SHALL cover a single request: port0 sends a=5, b=7, op LT -> ready0 high in the accept cycle; resp_valid0 after 2 edges with result=1, lt=1, ne=1.
REQ-030 SHALL cover an overflow corner: port1 sends a=0x80000000, b=0x7FFFFFFF, op GE -> result=0, lt=1.
REQ-031 SHALL cover a tie with RR_EN=1: both ports valid continuously, each with EQ on a=b=3 -> grants alternate 0,1,0,1; every response has result=1, ne=0, with 3 cycles between accepts while resp_ready is held high.
REQ-032 SHALL cover fixed priority: with RR_EN=0, both ports valid for 3 transactions -> port 0 gets all 3 grants and ready1 stays 0.
REQ-033 SHALL cover backpressure: hold resp_ready0=0 for 5 cycles in DONE, with port1 valid -> resp_valid0 and the outputs stay stable, busy=1 and ready1=0; port1 is accepted the cycle after consumption.
REQ-034 SHALL cover reset in BUSY: assert reset between clock edges -> busy drops immediately, no resp_valid appears, and the next tie is granted to port 0.
